// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel LED PWM with period-boundary double-buffered duties.
// Optional build macro RGB_PWM_PHASE_STAGGER_EN phase-offsets green by PERIOD/3
// and blue by 2*PERIOD/3 to spread the switching current; by default all three
// channels compare against the same count and turn on together at count 0.
module rgb_pwm #(
    parameter int PERIOD     = 8000,
    parameter int PRESCALE   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] red,
    input  logic [14:0] green,
    input  logic [14:0] blue,
    output logic        period_start,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [14:0] CNT_MAX = 15'(PERIOD - 1);
    localparam logic IDLE = ACTIVE_LOW != 0;

    logic [PW-1:0] pre_cnt;
    logic [14:0]   pwm_cnt;
    logic [14:0]   shadow_r, shadow_g, shadow_b;
    logic [14:0]   c_r, c_g, c_b;
    logic          tick, wrap;

    assign tick = pre_cnt == PRE_MAX;
    assign wrap = tick && pwm_cnt == CNT_MAX;

    // prescaler: one tick every PRESCALE clocks (every clock when PRESCALE is 1)
    always_ff @(posedge clk)
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

    // PWM count advances on tick and wraps at the end of the period
    always_ff @(posedge clk)
        if (rst)       pwm_cnt <= '0;
        else if (tick) pwm_cnt <= wrap ? '0 : pwm_cnt + 15'd1;

    // duties are captured only at the wrap so a period never mixes two duty values
    always_ff @(posedge clk)
        if (rst) begin
            period_start <= 1'b0;
            shadow_r     <= '0;
            shadow_g     <= '0;
            shadow_b     <= '0;
        end else begin
            period_start <= wrap;
            if (wrap) begin
                shadow_r <= red;
                shadow_g <= green;
                shadow_b <= blue;
            end
        end

`ifdef RGB_PWM_PHASE_STAGGER_EN
    localparam logic [15:0] PER16 = 16'(PERIOD);
    localparam logic [15:0] OFF_G = 16'(PERIOD / 3);
    localparam logic [15:0] OFF_B = 16'(2 * PERIOD / 3);

    logic [15:0] sum_g, sum_b;

    // offsets are below PERIOD, so one conditional subtract performs the modulo
    always_comb begin
        sum_g = {1'b0, pwm_cnt} + OFF_G;
        sum_b = {1'b0, pwm_cnt} + OFF_B;
        c_r   = pwm_cnt;
        c_g   = sum_g >= PER16 ? 15'(sum_g - PER16) : sum_g[14:0];
        c_b   = sum_b >= PER16 ? 15'(sum_b - PER16) : sum_b[14:0];
    end
`else
    assign c_r = pwm_cnt;
    assign c_g = pwm_cnt;
    assign c_b = pwm_cnt;
`endif

    // registered pins: gated by en, polarity flipped for active-low LEDs
    always_ff @(posedge clk)
        if (rst) begin
            led_r <= IDLE;
            led_g <= IDLE;
            led_b <= IDLE;
        end else begin
            led_r <= (en & (c_r < shadow_r)) ^ IDLE;
            led_g <= (en & (c_g < shadow_g)) ^ IDLE;
            led_b <= (en & (c_b < shadow_b)) ^ IDLE;
        end
endmodule

// File: tb/tb_rgb_pwm.sv
// tb_rgb_pwm: randomized and directed checks of rgb_pwm against a time-based reference model.
module tb_rgb_pwm;
    localparam int P = 8;
    localparam int PSV [3] = '{1, 3, 1};
    localparam bit ALV [3] = '{1'b0, 1'b0, 1'b1};
`ifdef RGB_PWM_PHASE_STAGGER_EN
    localparam int OFF [3] = '{0, P / 3, 2 * P / 3};
`else
    localparam int OFF [3] = '{0, 0, 0};
`endif

    logic clk = 1'b0;
    logic rst, en;
    logic [14:0] red, green, blue;
    wire [2:0] l0, l1, l2;
    wire p0, p1, p2;
    wire [2:0] led_o [3];
    wire [2:0] ps = {p2, p1, p0};
    int n_run = 0;
    int n_fail = 0;

    assign led_o[0] = l0;
    assign led_o[1] = l1;
    assign led_o[2] = l2;

    always #5 clk = ~clk;

    rgb_pwm #(.PERIOD(P), .PRESCALE(1), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
        .period_start(p0), .led_r(l0[0]), .led_g(l0[1]), .led_b(l0[2]));
    rgb_pwm #(.PERIOD(P), .PRESCALE(3), .ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
        .period_start(p1), .led_r(l1[0]), .led_g(l1[1]), .led_b(l1[2]));
    rgb_pwm #(.PERIOD(P), .PRESCALE(1), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .red(red), .green(green), .blue(blue),
        .period_start(p2), .led_r(l2[0]), .led_g(l2[1]), .led_b(l2[2]));

    // reference model: count position derived from clocks elapsed since reset
    int t [3];
    logic [14:0] sh [3][3];
    logic [2:0] exp_led [3];
    logic [2:0] exp_ps;

    always @(posedge clk) begin
        logic [14:0] din [3];
        int per, cnt;
        din[0] = red;
        din[1] = green;
        din[2] = blue;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                t[i] = 0;
                exp_led[i] = {3{ALV[i]}};
                exp_ps[i] = 1'b0;
                for (int c = 0; c < 3; c++) sh[i][c] = '0;
            end else begin
                per = PSV[i] * P;
                cnt = (t[i] / PSV[i]) % P;
                for (int c = 0; c < 3; c++)
                    exp_led[i][c] = (en && (((cnt + OFF[c]) % P) < int'(sh[i][c]))) ^ ALV[i];
                exp_ps[i] = (t[i] % per) == per - 1;
                if (exp_ps[i])
                    for (int c = 0; c < 3; c++) sh[i][c] = din[c];
                t[i]++;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; red = 15'd3; green = 15'd3; blue = 15'd3;
        repeat (3) begin
            @(negedge clk);
            n_run++;
            if ({l0, l1, l2} !== 9'b000_000_111 || ps !== 3'b000) begin
                n_fail++;
                $display("FAIL reset leds=%b ps=%b expected leds=000000111 ps=000", {l0, l1, l2}, ps);
            end
        end
    endtask

    task automatic test_basic;
        int pulses = 0;
        int hi [3] = '{0, 0, 0};
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_run++;
                if (led_o[i] !== exp_led[i] || ps[i] !== exp_ps[i]) begin
                    n_fail++;
                    $display("FAIL basic dut%0d k=%0d led=%b ps=%b expected led=%b ps=%b", i, k, led_o[i], ps[i], exp_led[i], exp_ps[i]);
                end
            end
            if (k <= 8) begin
                n_run++;
                if (l0 !== 3'b000) begin
                    n_fail++;
                    $display("FAIL basic_dark k=%0d led=%b expected 000", k, l0);
                end
            end
            if (k <= 9) pulses += int'(p0);
            if (k >= 9 && k <= 16)
                for (int c = 0; c < 3; c++) hi[c] += int'(l0[c]);
        end
        n_run++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL basic_first_pulse got %0d pulses expected 1", pulses);
        end
        for (int c = 0; c < 3; c++) begin
            n_run++;
            if (hi[c] != 3) begin
                n_fail++;
                $display("FAIL basic_duty ch%0d high %0d clk expected 3", c, hi[c]);
            end
        end
    endtask

    task automatic test_extremes;
        bit seen = 0;
        red = 15'd0; green = 15'd8; blue = 15'd20;
        for (int k = 0; k < 3 * P && !seen; k++) begin
            @(negedge clk);
            if (p0) seen = 1;
        end
        n_run++;
        if (!seen) begin
            n_fail++;
            $display("FAIL extremes_wait no period_start seen expected one");
        end
        repeat (8) begin
            @(negedge clk);
            n_run++;
            if (l0 !== 3'b110 || l0 !== exp_led[0]) begin
                n_fail++;
                $display("FAIL extremes led=%b expected 110 (model %b)", l0, exp_led[0]);
            end
        end
    endtask

    task automatic test_midchange;
        bit seen = 0;
        int hi_a = 0, hi_b = 0;
        red = 15'd2;
        @(negedge clk);
        for (int k = 0; k < 3 * P && !seen; k++) begin
            @(negedge clk);
            if (p0) seen = 1;
        end
        n_run++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midchange_wait no period_start seen expected one");
        end
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            n_run++;
            if (l0 !== exp_led[0]) begin
                n_fail++;
                $display("FAIL midchange_model j=%0d led=%b expected %b", j, l0, exp_led[0]);
            end
            if (j <= 8) hi_a += int'(l0[0]);
            else        hi_b += int'(l0[0]);
            if (j == 4) red = 15'd6;
        end
        n_run++;
        if (hi_a != 2 || hi_b != 6) begin
            n_fail++;
            $display("FAIL midchange red high %0d/%0d clk expected 2/6", hi_a, hi_b);
        end
    endtask

    task automatic test_prescale;
        int pulse_at [$];
        int hi = 0;
        red = 15'd4;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            n_run++;
            if (l1 !== exp_led[1] || p1 !== exp_ps[1]) begin
                n_fail++;
                $display("FAIL prescale_model k=%0d led=%b ps=%b expected led=%b ps=%b", k, l1, p1, exp_led[1], exp_ps[1]);
            end
            if (p1) pulse_at.push_back(k);
            if (pulse_at.size() == 1 && k > pulse_at[0] && k <= pulse_at[0] + 24) hi += int'(l1[0]);
        end
        n_run++;
        if (pulse_at.size() < 3) begin
            n_fail++;
            $display("FAIL prescale_pulses got %0d pulses expected at least 3", pulse_at.size());
        end
        for (int i = 1; i < pulse_at.size(); i++) begin
            n_run++;
            if (pulse_at[i] - pulse_at[i-1] != 24) begin
                n_fail++;
                $display("FAIL prescale_spacing got %0d clk expected 24", pulse_at[i] - pulse_at[i-1]);
            end
        end
        n_run++;
        if (hi != 12) begin
            n_fail++;
            $display("FAIL prescale_duty red high %0d clk expected 12", hi);
        end
    endtask

    task automatic test_active_low;
        bit seen = 0;
        int lo = 0;
        red = 15'd5;
        @(negedge clk);
        for (int k = 0; k < 3 * P && !seen; k++) begin
            @(negedge clk);
            if (p2) seen = 1;
        end
        n_run++;
        if (!seen) begin
            n_fail++;
            $display("FAIL active_low_wait no period_start seen expected one");
        end
        repeat (8) begin
            @(negedge clk);
            lo += int'(!l2[0]);
        end
        n_run++;
        if (lo != 5) begin
            n_fail++;
            $display("FAIL active_low_duty red low %0d clk expected 5", lo);
        end
        en = 1'b0;
        repeat (8) begin
            @(negedge clk);
            n_run++;
            if (l2 !== 3'b111 || l0 !== 3'b000 || l2 !== exp_led[2]) begin
                n_fail++;
                $display("FAIL en_off led2=%b led0=%b expected 111 and 000", l2, l0);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_rst_mid;
        bit seen = 0;
        red = 15'd8; green = 15'd8; blue = 15'd8;
        @(negedge clk);
        for (int k = 0; k < 3 * P && !seen; k++) begin
            @(negedge clk);
            if (p0) seen = 1;
        end
        repeat (3) @(negedge clk);
        n_run++;
        if (!seen || l0 !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_mid_pre seen=%0d led=%b expected 1 and 111", seen, l0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_run++;
        if ({l0, l1, l2} !== 9'b000_000_111 || ps !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid leds=%b ps=%b expected leds=000000111 ps=000", {l0, l1, l2}, ps);
        end
        repeat (8) begin
            @(negedge clk);
            n_run++;
            if (l0 !== 3'b000) begin
                n_fail++;
                $display("FAIL rst_mid_dark led=%b expected 000", l0);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_run++;
                if (led_o[i] !== exp_led[i] || ps[i] !== exp_ps[i]) begin
                    n_fail++;
                    $display("FAIL random dut%0d k=%0d led=%b ps=%b expected led=%b ps=%b", i, k, led_o[i], ps[i], exp_led[i], exp_ps[i]);
                end
            end
            if ($urandom_range(0, 4) == 0) red   = 15'($urandom_range(0, 12));
            if ($urandom_range(0, 4) == 0) green = 15'($urandom_range(0, 12));
            if ($urandom_range(0, 4) == 0) blue  = 15'($urandom_range(0, 12));
            en  = $urandom_range(0, 7) != 0;
            rst = $urandom_range(0, 59) == 0;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; red = '0; green = '0; blue = '0;
        test_reset;
        test_basic;
        test_extremes;
        test_midchange;
        test_prescale;
        test_active_low;
        test_rst_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
